// File: rtl/rgb_sequencer.sv
// Timed colour sequencer feeding the RGB LED decoder's 3-bit code input.
// Steps through codes 0-6 as UP, DOWN, PINGPONG or BLINK; code 7 means all-off.
module rgb_sequencer #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic [2:0] sel,
    output logic [2:0] code,
    output logic       running,
    output logic       step,
    output logic       wrap
);

    localparam int             PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [2:0]     CODE_OFF  = 3'd7;
    localparam logic [2:0]     CODE_TOP  = 3'd6;
    localparam logic [1:0]     M_UP      = 2'b00;
    localparam logic [1:0]     M_DOWN    = 2'b01;
    localparam logic [1:0]     M_PING    = 2'b10;
    localparam logic [1:0]     M_BLINK   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    code_q, code_d;
    logic [1:0]    mode_q, mode_d;
    logic [2:0]    sel_q, sel_d;
    logic          dir_q, dir_d;       // 0 = counting up, 1 = counting down
    logic          phase_q, phase_d;   // blink: 0 = showing sel, 1 = dark
    logic          step_q, step_d;
    logic          wrap_q, wrap_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            code_q  <= CODE_OFF;
            mode_q  <= M_UP;
            sel_q   <= 3'd0;
            dir_q   <= 1'b0;
            phase_q <= 1'b0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            code_q  <= code_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        code_d  = code_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!stop && start) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    sel_d   = sel;
                    presc_d = '0;
                    dir_d   = 1'b0;
                    phase_d = 1'b0;
                    unique case (mode)
                        M_UP:    code_d = 3'd0;
                        M_DOWN:  code_d = CODE_TOP;
                        M_PING:  code_d = 3'd0;
                        M_BLINK: code_d = sel;
                    endcase
                end
            end

            S_RUN: begin
                // stop wins over a coinciding tick, so no step is emitted
                if (stop) begin
                    state_d = S_PAUSE;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    step_d  = 1'b1;
                    unique case (mode_q)
                        M_UP: begin
                            if (code_q == CODE_TOP) begin
                                code_d = 3'd0;
                                wrap_d = 1'b1;
                            end else begin
                                code_d = code_q + 3'd1;
                            end
                        end
                        M_DOWN: begin
                            if (code_q == 3'd0) begin
                                code_d = CODE_TOP;
                                wrap_d = 1'b1;
                            end else begin
                                code_d = code_q - 3'd1;
                            end
                        end
                        M_PING: begin
                            if (!dir_q) begin
                                if (code_q == CODE_TOP) begin
                                    dir_d  = 1'b1;
                                    code_d = code_q - 3'd1;
                                end else begin
                                    code_d = code_q + 3'd1;
                                end
                            end else begin
                                if (code_q == 3'd0) begin
                                    dir_d  = 1'b0;
                                    code_d = 3'd1;
                                end else begin
                                    code_d = code_q - 3'd1;
                                    wrap_d = (code_q == 3'd1);
                                end
                            end
                        end
                        M_BLINK: begin
                            phase_d = ~phase_q;
                            if (phase_q) begin
                                code_d = sel_q;
                                wrap_d = 1'b1;
                            end else begin
                                code_d = CODE_OFF;
                            end
                        end
                    endcase
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    code_d  = CODE_OFF;
                end else if (start) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                code_d  = CODE_OFF;
            end
        endcase
    end

    assign code    = code_q;
    assign running = (state_q == S_RUN);
    assign step    = step_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_rgb_sequencer.sv
// Directed bench for rgb_sequencer with TICK_DIV = 4 and hand-computed code sequences.
module tb_rgb_sequencer;

    localparam int TD = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [2:0] sel;
    logic [2:0] code;
    logic       running;
    logic       step;
    logic       wrap;

    int n_vec = 0;
    int n_err = 0;

    rgb_sequencer #(.TICK_DIV(TD)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .sel     (sel),
        .code    (code),
        .running (running),
        .step    (step),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // TD-1 quiet edges, then one edge that must step to exp_code
    task automatic step_chk(input string tag, input logic [2:0] exp_code, input logic exp_wrap);
        for (int i = 0; i < TD - 1; i++) begin
            tick();
            chk({tag, "_quiet"}, {31'd0, step}, 32'd0);
        end
        tick();
        chk({tag, "_code"}, {29'd0, code}, {29'd0, exp_code});
        chk({tag, "_step"}, {31'd0, step}, 32'd1);
        chk({tag, "_wrap"}, {31'd0, wrap}, {31'd0, exp_wrap});
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [2:0] s);
        mode  = m;
        sel   = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    logic [2:0] up_seq   [7]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    logic [2:0] down_seq [7]  = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd6};
    logic [2:0] ping_seq [13] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5,
                                  3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; sel = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_code", {29'd0, code}, 32'd7);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_step", {31'd0, step}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);

        pulse_stop();
        chk("idle_stop_code", {29'd0, code}, 32'd7);

        // UP
        pulse_start(2'b00, 3'd0);
        chk("up_load", {29'd0, code}, 32'd0);
        chk("up_running", {31'd0, running}, 32'd1);
        chk("up_load_step", {31'd0, step}, 32'd0);
        for (int i = 0; i < 7; i++) step_chk("up", up_seq[i], i == 6);
        pulse_stop();
        chk("up_pause_run", {31'd0, running}, 32'd0);
        pulse_stop();
        chk("up_idle_code", {29'd0, code}, 32'd7);

        // DOWN
        pulse_start(2'b01, 3'd0);
        chk("down_load", {29'd0, code}, 32'd6);
        for (int i = 0; i < 7; i++) step_chk("down", down_seq[i], i == 6);
        pulse_stop();
        pulse_stop();

        // PINGPONG
        pulse_start(2'b10, 3'd0);
        chk("ping_load", {29'd0, code}, 32'd0);
        for (int i = 0; i < 13; i++) step_chk("ping", ping_seq[i], i == 11);
        pulse_stop();
        pulse_stop();

        // BLINK, sel changed mid-run must be ignored
        pulse_start(2'b11, 3'd3);
        chk("blink_load", {29'd0, code}, 32'd3);
        step_chk("blink", 3'd7, 1'b0);
        step_chk("blink", 3'd3, 1'b1);
        sel  = 3'd5;
        mode = 2'b00;
        step_chk("blink_sel", 3'd7, 1'b0);
        step_chk("blink_sel", 3'd3, 1'b1);
        pulse_stop();
        pulse_stop();

        // BLINK of the off code
        pulse_start(2'b11, 3'd7);
        chk("blink7_load", {29'd0, code}, 32'd7);
        step_chk("blink7", 3'd7, 1'b0);
        step_chk("blink7", 3'd7, 1'b1);
        pulse_stop();
        pulse_stop();

        // Pause at code 4, hold, resume
        pulse_start(2'b00, 3'd0);
        for (int i = 0; i < 4; i++) step_chk("pr", up_seq[i], 1'b0);
        pulse_stop();
        chk("pause_code", {29'd0, code}, 32'd4);
        chk("pause_running", {31'd0, running}, 32'd0);
        repeat (20) tick();
        chk("pause_hold_code", {29'd0, code}, 32'd4);
        chk("pause_hold_running", {31'd0, running}, 32'd0);
        chk("pause_hold_step", {31'd0, step}, 32'd0);
        pulse_start(2'b01, 3'd0);
        chk("resume_running", {31'd0, running}, 32'd1);
        chk("resume_code", {29'd0, code}, 32'd4);
        step_chk("resume", 3'd5, 1'b0);

        // start and stop together: RUN -> PAUSE -> IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        chk("both_run_running", {31'd0, running}, 32'd0);
        chk("both_run_code", {29'd0, code}, 32'd5);
        tick();
        start = 1'b0; stop = 1'b0;
        chk("both_pause_code", {29'd0, code}, 32'd7);
        chk("both_pause_running", {31'd0, running}, 32'd0);

        // stop landing on a tick edge suppresses the step
        pulse_start(2'b00, 3'd0);
        repeat (TD - 1) tick();
        pulse_stop();
        chk("stoptick_step", {31'd0, step}, 32'd0);
        chk("stoptick_code", {29'd0, code}, 32'd0);
        chk("stoptick_running", {31'd0, running}, 32'd0);
        pulse_start(2'b00, 3'd0);
        step_chk("stoptick_resume", 3'd1, 1'b0);

        // reset on a tick edge with start high
        repeat (TD - 1) tick();
        rst = 1'b1; start = 1'b1;
        tick();
        chk("mrst_code", {29'd0, code}, 32'd7);
        chk("mrst_running", {31'd0, running}, 32'd0);
        chk("mrst_step", {31'd0, step}, 32'd0);
        chk("mrst_wrap", {31'd0, wrap}, 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("mrst_idle_code", {29'd0, code}, 32'd7);
        chk("mrst_idle_running", {31'd0, running}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
